// File: rtl/comparator_4b_pkg.sv
// comparator_4b_pkg: shared width and result encoding for the 4-bit comparator
// CMP_W     : operand width
// cmp_res_e : one-hot {gt,lt,eq} result code, all-zero meaning no result
package comparator_4b_pkg;
    localparam int CMP_W = 4;
    typedef enum logic [2:0] {
        CMP_NONE = 3'b000,
        CMP_GT   = 3'b100,
        CMP_LT   = 3'b010,
        CMP_EQ   = 3'b001
    } cmp_res_e;
endpackage

// File: rtl/comparator_bit.sv
// comparator_bit: single-bit compare slice
// a, b : operand bits
// eq   : a equals b
// gt   : a is 1 and b is 0
// lt   : a is 0 and b is 1
module comparator_bit (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);
    assign eq = ~(a ^ b);
    assign gt = a & ~b;
    assign lt = ~a & b;
endmodule

// File: rtl/comparator_4b.sv
// comparator_4b: registered 4-bit unsigned magnitude comparator
// clk, rst_n       : rising-edge clock, synchronous active-low reset
// a0..a3, b0..b3   : operand bits of A and B, LSB first
// AgtB, AltB, AeqB : registered one-hot result, all-zero while in reset
module comparator_4b
    import comparator_4b_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic AgtB,
    output logic AltB,
    output logic AeqB
);
    logic [CMP_W-1:0] a, b, e, g, l;
    logic gt, lt, eq;
    cmp_res_e res_d, res_q;
    assign a = {a3, a2, a1, a0};
    assign b = {b3, b2, b1, b0};
    for (genvar i = 0; i < CMP_W; i++) begin : g_slice
        comparator_bit u_bit (.a(a[i]), .b(b[i]), .eq(e[i]), .gt(g[i]), .lt(l[i]));
    end
    // The first differing bit from the MSB down decides the result.
    assign gt = g[3] | e[3] & g[2] | e[3] & e[2] & g[1] | e[3] & e[2] & e[1] & g[0];
    assign lt = l[3] | e[3] & l[2] | e[3] & e[2] & l[1] | e[3] & e[2] & e[1] & l[0];
    assign eq = &e;
    always_comb res_d = gt ? CMP_GT : lt ? CMP_LT : eq ? CMP_EQ : CMP_NONE;
    always_ff @(posedge clk) res_q <= !rst_n ? CMP_NONE : res_d;
    assign {AgtB, AltB, AeqB} = res_q;
endmodule

// File: tb/tb_comparator_4b.sv
// tb_comparator_4b: directed and exhaustive self-checking bench for comparator_4b
module tb_comparator_4b;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] a = 4'd0, b = 4'd0;
    logic AgtB, AltB, AeqB;
    int n_cmp = 0;
    int n_bad = 0;

    comparator_4b dut (
        .clk(clk), .rst_n(rst_n),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
        .AgtB(AgtB), .AltB(AltB), .AeqB(AeqB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [3:0] x, input logic [3:0] y);
        return x > y ? 3'b100 : x < y ? 3'b010 : 3'b001;
    endfunction

    // Drive operands away from the edge, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] x, input logic [3:0] y, input logic r);
        @(negedge clk);
        a = x;
        b = y;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] x, input logic [3:0] y, input logic [2:0] exp);
        step(x, y, 1'b1);
        check(tag, {AgtB, AltB, AeqB}, exp);
    endtask

    initial begin
        step(4'd5, 4'd3, 1'b0);
        check("reset_edge1", {AgtB, AltB, AeqB}, 3'b000);
        step(4'd5, 4'd3, 1'b0);
        check("reset_edge2", {AgtB, AltB, AeqB}, 3'b000);
        vec("release_5_3", 4'd5, 4'd3, 3'b100);
        vec("bnd_0_0", 4'd0, 4'd0, 3'b001);
        vec("bnd_15_15", 4'd15, 4'd15, 3'b001);
        vec("bnd_15_0", 4'd15, 4'd0, 3'b100);
        vec("bnd_0_15", 4'd0, 4'd15, 3'b010);
        vec("msb_8_7", 4'd8, 4'd7, 3'b100);
        vec("msb_7_8", 4'd7, 4'd8, 3'b010);
        vec("lsb_6_7", 4'd6, 4'd7, 3'b010);
        vec("lsb_7_6", 4'd7, 4'd6, 3'b100);
        for (int i = 0; i < 256; i++) begin
            step(4'(i >> 4), 4'(i), 1'b1);
            check("sweep", {AgtB, AltB, AeqB}, model(4'(i >> 4), 4'(i)));
            check("onehot", 3'($countones({AgtB, AltB, AeqB})), 3'd1);
        end
        for (int i = 0; i < 8; i++) begin
            step(4'(i * 3), 4'(15 - i * 2), i != 4);
            check(i == 4 ? "mid_reset" : "mid_sweep", {AgtB, AltB, AeqB},
                  i == 4 ? 3'b000 : model(4'(i * 3), 4'(15 - i * 2)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/comparator_4b.md
# comparator_4b

4-bit unsigned magnitude comparator with registered outputs. Takes two nibbles, A and B, presented as individual bit ports. Each clock it reports exactly one of greater, less or equal. It serves as a leaf compare element in datapath control logic, where single-bit port granularity lets callers wire scattered bits directly.

## Interface
- No parameters; width fixed at 4 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a0  input  1  A bit 0 (LSB).
- a1  input  1  A bit 1.
- a2  input  1  A bit 2.
- a3  input  1  A bit 3 (MSB).
- b0  input  1  B bit 0 (LSB).
- b1  input  1  B bit 1.
- b2  input  1  B bit 2.
- b3  input  1  B bit 3 (MSB).
- AgtB  output  1  registered, 1 when A > B (unsigned).
- AltB  output  1  registered, 1 when A < B (unsigned).
- AeqB  output  1  registered, 1 when A == B.
- One clock; reset is synchronous and active-low.

## Operation
- A = {a3,a2,a1,a0}, B = {b3,b2,b1,b0}, both unsigned 0..15.
- Per-bit slice i computes:
  - e_i = ~(a_i ^ b_i)
  - g_i = a_i & ~b_i
  - l_i = ~a_i & b_i
- Combine MSB-first with priority:
  - gt = g3 | e3&g2 | e3&e2&g1 | e3&e2&e1&g0
  - lt is the same form using l_i.
  - eq = e3&e2&e1&e0
- Outside reset, exactly one of AgtB/AltB/AeqB is 1 (one-hot invariant).
- No enable and no hold: the compare result is re-registered every cycle.
- X/Z on inputs is not a supported condition; behaviour is undefined.

## Timing
- All outputs are flops clocked on the rising edge of clk.
- Latency: 1 cycle. Inputs stable at edge N give the result valid after edge N, held until edge N+1.
- Input changes between edges never reach the outputs until the next edge, so outputs are glitch-free.
- Reset: if rst_n = 0 at a rising edge, AgtB = 0, AltB = 0, AeqB = 0 after that edge. All-zero means "no result".
- First valid result follows the first edge with rst_n = 1.
- Reset asserted mid-stream clears the outputs at the next edge regardless of inputs. No other state exists.
- Back-to-back operand changes every cycle are supported at full throughput.

## Structure
- Shared package holds:
  - CMP_W = 4
  - A 3-bit result encoding (GT, LT, EQ, NONE) for bench and consumers.
- One sub-module, comparator_bit, is natural. It is instantiated 4 times:
  - inputs a, b
  - outputs eq, gt, lt
- Top level contains:
  - the priority combine network
  - the 3-flop output register with synchronous reset.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with A = 5, B = 3 -> AgtB/AltB/AeqB = 0/0/0. Release; after next edge -> 1/0/0.
- Exhaustive sweep: all 256 (A,B) pairs, one per cycle. Check outputs one cycle later against A>B, A<B, A==B, and check the one-hot invariant on every cycle.
- Boundaries:
  - A = 0, B = 0 -> AeqB
  - A = 15, B = 15 -> AeqB
  - A = 15, B = 0 -> AgtB
  - A = 0, B = 15 -> AltB
- MSB priority:
  - A = 8 (1000), B = 7 (0111) -> AgtB
  - A = 7, B = 8 -> AltB
- LSB-only difference:
  - A = 6, B = 7 -> AltB
  - A = 7, B = 6 -> AgtB
- Mid-stream reset: sweep running, assert rst_n = 0 for 1 edge -> outputs 0/0/0 for that cycle. Correct results resume from the following edge.
